// File: rtl/fetch_aligner.sv
// fetch_aligner: instruction-side reader of the program memory.
// Issues word-aligned fetch addresses and splits the returned 32-bit
// little-endian word stream into whole RV32I / RVC instructions, including
// 32-bit instructions that straddle a word boundary. Results reach decode
// through a registered valid/ready handshake. Redirects from branch/jump
// resolution override everything else.
//
// Build option: define FETCH_ALIGN_RVC_EN for full compressed-instruction
// support (ALIGNED/HOLD/SKIP states). When it is undefined, every
// instruction is 32-bit, out_is_rvc is tied low and redirect targets are
// forced word-aligned.
module fetch_aligner #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic        out_is_rvc
);

    // PC of the next instruction to emit, and the word address being read.
    logic [31:0] pc;
    logic [31:0] fetch_addr;
    logic        adv;

    // The output register may be refilled when it is empty or being taken.
    assign adv      = !out_valid || out_ready;
    assign mem_addr = fetch_addr;

`ifdef FETCH_ALIGN_RVC_EN

    localparam logic [1:0] ALIGNED = 2'd0;  // pc[1]=0
    localparam logic [1:0] HOLD    = 2'd1;  // pc[1]=1, upper half held
    localparam logic [1:0] SKIP    = 2'd2;  // pc[1]=1, nothing held yet

    logic [1:0]  state;
    logic [15:0] hold;
    logic        hold_valid;
    logic        hold_is_rvc;
    logic        rdata_is_rvc;
    logic        unused_redirect_bit;

    // Halfword targets are 2-byte aligned, so bit 0 carries no information.
    assign unused_redirect_bit = redirect_pc[0];

    // A 32-bit instruction always has 2'b11 in the low two bits of its low half.
    assign hold_is_rvc  = hold[1:0] != 2'b11;
    assign rdata_is_rvc = mem_rdata[1:0] != 2'b11;

    // Alignment state machine, halfword buffer and registered output stage.
    // NOTE: every register here is written with <= so all next-state terms
    // see the values from before this edge, regardless of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ALIGNED;
            pc         <= RESET_PC;
            fetch_addr <= RESET_PC;
            hold       <= 16'h0;
            hold_valid <= 1'b0;
            out_valid  <= 1'b0;
            out_instr  <= 32'h0;
            out_pc     <= 32'h0;
            out_is_rvc <= 1'b0;
        end else if (redirect_valid) begin
            // Redirect beats any handshake; the pending output is discarded.
            out_valid  <= 1'b0;
            pc         <= {redirect_pc[31:1], 1'b0};
            fetch_addr <= {redirect_pc[31:2], 2'b00};
            hold_valid <= 1'b0;
            state      <= redirect_pc[1] ? SKIP : ALIGNED;
        end else if (state == SKIP) begin
            // Only the upper half of this word belongs to the target stream.
            hold       <= mem_rdata[31:16];
            hold_valid <= 1'b1;
            fetch_addr <= fetch_addr + 32'd4;
            state      <= HOLD;
        end else if (adv) begin
            out_valid <= 1'b1;
            out_pc    <= pc;
            if (state == HOLD && hold_valid) begin
                if (hold_is_rvc) begin
                    // Held half is a full instruction; the current word stays put.
                    out_instr  <= {16'h0, hold};
                    out_is_rvc <= 1'b1;
                    pc         <= pc + 32'd2;
                    hold_valid <= 1'b0;
                    state      <= ALIGNED;
                end else begin
                    // Straddling instruction: held half is low, new word supplies high.
                    out_instr  <= {mem_rdata[15:0], hold};
                    out_is_rvc <= 1'b0;
                    pc         <= pc + 32'd4;
                    hold       <= mem_rdata[31:16];
                    fetch_addr <= fetch_addr + 32'd4;
                end
            end else if (rdata_is_rvc) begin
                out_instr  <= {16'h0, mem_rdata[15:0]};
                out_is_rvc <= 1'b1;
                pc         <= pc + 32'd2;
                hold       <= mem_rdata[31:16];
                hold_valid <= 1'b1;
                fetch_addr <= fetch_addr + 32'd4;
                state      <= HOLD;
            end else begin
                out_instr  <= mem_rdata;
                out_is_rvc <= 1'b0;
                pc         <= pc + 32'd4;
                fetch_addr <= fetch_addr + 32'd4;
            end
        end
    end

`else

    logic [1:0] unused_redirect_bits;

    // Without compressed support every target is forced word-aligned.
    assign unused_redirect_bits = redirect_pc[1:0];
    assign out_is_rvc           = 1'b0;

    // Word-per-instruction fetch with a registered output stage.
    // NOTE: every register here is written with <= so all next-state terms
    // see the values from before this edge, regardless of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc         <= RESET_PC;
            fetch_addr <= RESET_PC;
            out_valid  <= 1'b0;
            out_instr  <= 32'h0;
            out_pc     <= 32'h0;
        end else if (redirect_valid) begin
            out_valid  <= 1'b0;
            pc         <= {redirect_pc[31:2], 2'b00};
            fetch_addr <= {redirect_pc[31:2], 2'b00};
        end else if (adv) begin
            out_valid  <= 1'b1;
            out_pc     <= pc;
            out_instr  <= mem_rdata;
            pc         <= pc + 32'd4;
            fetch_addr <= fetch_addr + 32'd4;
        end
    end

`endif

endmodule
